// File: rtl/signal_check_mc_pkg.sv
// Shared edge-mode and channel-state encodings for the multi-channel signal checker.
package signal_check_mc_pkg;

   typedef logic [1:0] edge_mode_t;

   localparam edge_mode_t EDGE_NONE = 2'b00;
   localparam edge_mode_t EDGE_RISE = 2'b01;
   localparam edge_mode_t EDGE_FALL = 2'b10;
   localparam edge_mode_t EDGE_BOTH = 2'b11;

   localparam logic [1:0] ST_DIS  = 2'b00;
   localparam logic [1:0] ST_INIT = 2'b01;
   localparam logic [1:0] ST_RUN  = 2'b10;

endpackage

// File: rtl/signal_check_ch.sv
// One channel: synchroniser, ms stability filter, enable FSM, edge decode, sticky flag/overflow.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_DIS  | channel disabled, counter held at 0, level frozen, no events
// ST_INIT | waiting for first qualified level, adopted without an event
// ST_RUN  | qualified level changes are decoded into events
module signal_check_ch
   import signal_check_mc_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             si,
   input  logic             ch_en,
   input  logic [1:0]       edge_type,
   input  logic [CNT_W-1:0] fms,
   input  logic             ms_pulse,
   input  logic             irq_clr,
   output logic             level,
   output logic             into,
   output logic             irq_flag,
   output logic             ovf
);

   logic [2:0]       si_dly;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       state;
   logic             level_dly;
   logic             rise_q;
   logic             fall_q;
   logic             stable;
   logic             active;
   logic             qualify;
   logic             rise_sel;
   logic             fall_sel;

   assign stable   = (si_dly[1] == si_dly[2]);
   assign active   = ch_en && (state != ST_DIS);
   assign qualify  = active && stable && ms_pulse && (cnt >= fms);
   assign rise_sel = (edge_type == EDGE_RISE) || (edge_type == EDGE_BOTH);
   assign fall_sel = (edge_type == EDGE_FALL) || (edge_type == EDGE_BOTH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         si_dly <= '0;
      end else begin
         si_dly <= {si_dly[1:0], si};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!active || !stable) begin
         cnt <= '0;
      end else if (ms_pulse && (cnt < fms)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_INIT;
      end else if (!ch_en) begin
         state <= ST_DIS;
      end else begin
         case (state)
            ST_DIS:  state <= ST_INIT;
            ST_INIT: if (qualify) state <= ST_RUN;
            ST_RUN:  state <= ST_RUN;
            default: state <= ST_INIT;
         endcase
      end
   end

   // In INIT the delayed copy is loaded together with level, so adopting the
   // first qualified value never looks like an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level     <= 1'b0;
         level_dly <= 1'b0;
      end else begin
         if (qualify) level <= si_dly[1];
         if (qualify && (state == ST_INIT)) level_dly <= si_dly[1];
         else                               level_dly <= level;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         into   <= 1'b0;
      end else begin
         rise_q <= level & ~level_dly;
         fall_q <= ~level & level_dly;
         into   <= (rise_q & rise_sel) | (fall_q & fall_sel);
      end
   end

   // A new event wins over a same-cycle clear for the flag; the clear wins for ovf.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_flag <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         irq_flag <= into | (irq_flag & ~irq_clr);
         if (irq_clr) ovf <= 1'b0;
         else         ovf <= ovf | (into & irq_flag);
      end
   end

endmodule

// File: rtl/signal_check_mc.sv
// Multi-channel debounce/edge-interrupt checker: CH_NUM independent channels and one
// registered, maskable aggregate interrupt.
module signal_check_mc
   import signal_check_mc_pkg::*;
#(
   parameter int CH_NUM = 8,
   parameter int CNT_W  = 8,
   // Register delay is a simulation-only notion and is not modelled in this RTL.
   parameter int U_DLY  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [CH_NUM-1:0]       si,
   input  logic [CH_NUM-1:0]       ch_en,
   input  logic [2*CH_NUM-1:0]     edge_type,
   input  logic [CNT_W*CH_NUM-1:0] fms,
   input  logic                    ms_pulse,
   input  logic [CH_NUM-1:0]       irq_mask,
   input  logic [CH_NUM-1:0]       irq_clr,
   output logic [CH_NUM-1:0]       level,
   output logic [CH_NUM-1:0]       into,
   output logic [CH_NUM-1:0]       irq_flag,
   output logic [CH_NUM-1:0]       ovf,
   output logic                    irq
);

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      signal_check_ch #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .si        (si[i]),
         .ch_en     (ch_en[i]),
         .edge_type (edge_type[2*i +: 2]),
         .fms       (fms[CNT_W*i +: CNT_W]),
         .ms_pulse  (ms_pulse),
         .irq_clr   (irq_clr[i]),
         .level     (level[i]),
         .into      (into[i]),
         .irq_flag  (irq_flag[i]),
         .ovf       (ovf[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq <= 1'b0;
      end else begin
         irq <= |(irq_flag & irq_mask);
      end
   end

endmodule
